// File: rtl/dip_pkg.sv
// ----------------------------------------------------------------------------
// dip_pkg
// Shared definitions for the DIP/configuration bank loader: the loader state
// encoding, the largest supported bank size and the ioctl index that hps_io
// conventionally uses for DIP switch downloads.
// No ports (package).
// ----------------------------------------------------------------------------
package dip_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } dip_state_t;

    localparam int         MAX_DIP_BYTES     = 32;
    localparam logic [7:0] DIP_INDEX_DEFAULT = 8'd254;

endpackage

// File: rtl/dip_bank_loader.sv
// ----------------------------------------------------------------------------
// dip_bank_loader
// DIP/configuration register bank fed from the hps_io ioctl download stream.
// Bytes of a download addressed to DIP_INDEX are collected in a shadow bank
// and copied to the live bank in a single cycle once the download ends, so the
// core never sees a half-written switch setting.
//
// Ports (all in the clk_sys domain):
//   clk_sys        in   system clock, rising edge
//   RESET_N        in   asynchronous active-low reset
//   ioctl_download in   download-active level
//   ioctl_index    in   download target index, qualified only at download start
//   ioctl_wr       in   one-cycle byte write strobe
//   ioctl_addr     in   byte address within the download (full 25 bits compared)
//   ioctl_dout     in   byte data
//   dip_out        out  live bank, byte n in bits [8n+7:8n]
//   dip_valid      out  a complete (all bytes written) download has been committed
//   dip_update     out  one-cycle pulse when dip_out has just been reloaded
//   load_err       out  last commit was short and/or had out-of-range writes
//   busy           out  loader is not idle
// ----------------------------------------------------------------------------
module dip_bank_loader
    import dip_pkg::*;
#(
    parameter int                     NUM_BYTES = 8,
    parameter logic [7:0]             DIP_INDEX = DIP_INDEX_DEFAULT,
    parameter logic [NUM_BYTES*8-1:0] DEFAULT   = '0
) (
    input  logic                   clk_sys,
    input  logic                   RESET_N,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic [NUM_BYTES*8-1:0] dip_out,
    output logic                   dip_valid,
    output logic                   dip_update,
    output logic                   load_err,
    output logic                   busy
);

    localparam logic [24:0] NUM_BYTES_ADDR = 25'(NUM_BYTES);

    dip_state_t state, state_nxt;

    logic                   dl_d;
    logic                   dl_armed;
    logic                   dl_rise;
    logic                   dl_fall;
    logic                   bank_rise;
    logic                   wr_accept;
    logic [NUM_BYTES*8-1:0] shadow;
    logic [NUM_BYTES-1:0]   mask;
    logic                   ovf;

    // A rise only counts once download has been seen low since reset, so a
    // download that was already running when reset hit is ignored to its end.
    assign dl_rise   = ioctl_download & ~dl_d & dl_armed;
    assign dl_fall   = ~ioctl_download & dl_d;
    assign bank_rise = (state == IDLE) & dl_rise & (ioctl_index == DIP_INDEX);

    // The rise-entry cycle already accepts a write so a strobe coincident with
    // the download start is not lost.
    assign wr_accept = ioctl_wr & ioctl_download & ((state == LOAD) | bank_rise);

    assign busy = (state != IDLE);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            dl_d     <= 1'b0;
            dl_armed <= 1'b0;
        end else begin
            dl_d <= ioctl_download;
            if (!ioctl_download) begin
                dl_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bank_rise) state_nxt = LOAD;
            LOAD:    if (dl_fall)   state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow bank: seeded from the live bank at download start so unwritten
    // bytes keep their value; the byte write below is ordered after the seed
    // so a write in the entry cycle wins for its byte.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow <= DEFAULT;
            mask   <= '0;
            ovf    <= 1'b0;
        end else begin
            if (bank_rise) begin
                shadow <= dip_out;
                mask   <= '0;
                ovf    <= 1'b0;
            end
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_accept && (ioctl_addr == 25'(i))) begin
                    shadow[i*8 +: 8] <= ioctl_dout;
                    mask[i]          <= 1'b1;
                end
            end
            if (wr_accept && (ioctl_addr >= NUM_BYTES_ADDR)) begin
                ovf <= 1'b1;
            end
        end
    end

    // Live bank and status are only touched in the single COMMIT cycle.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            dip_out    <= DEFAULT;
            dip_valid  <= 1'b0;
            dip_update <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            dip_update <= 1'b0;
            if (state == COMMIT) begin
                dip_out    <= shadow;
                dip_update <= 1'b1;
                load_err   <= ~(&mask) | ovf;
                dip_valid  <= dip_valid | (&mask);
            end
        end
    end

endmodule

// File: tb/tb_dip_bank_loader.sv
// ----------------------------------------------------------------------------
// tb_dip_bank_loader
// Directed bench for dip_bank_loader. Two instances share the ioctl stream:
// an 8-byte bank with a non-zero power-on value and a 10-byte bank used to
// show that the same long stream is not an overflow for a larger bank.
// ----------------------------------------------------------------------------
module tb_dip_bank_loader;

    localparam logic [63:0] DEF8 = 64'h0123_4567_89AB_CDEF;

    typedef struct packed {
        logic [63:0] out;
        logic        err;
        logic        valid;
    } commit_t;

    logic        clk_sys;
    logic        RESET_N;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [63:0] dip_out8;
    logic        dip_valid8, dip_update8, load_err8, busy8;
    logic [79:0] dip_out10;
    logic        dip_valid10, dip_update10, load_err10, busy10;

    int          checks   = 0;
    int          failures = 0;

    commit_t     sb[$];
    int          stimAddr[$];
    logic [7:0]  stimData[$];
    logic [63:0] mLive;
    logic        mValid;

    dip_bank_loader #(
        .NUM_BYTES (8),
        .DIP_INDEX (8'd254),
        .DEFAULT   (DEF8)
    ) dut8 (
        .clk_sys        (clk_sys),
        .RESET_N        (RESET_N),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dip_out        (dip_out8),
        .dip_valid      (dip_valid8),
        .dip_update     (dip_update8),
        .load_err       (load_err8),
        .busy           (busy8)
    );

    dip_bank_loader #(
        .NUM_BYTES (10),
        .DIP_INDEX (8'd254),
        .DEFAULT   (80'h0)
    ) dut10 (
        .clk_sys        (clk_sys),
        .RESET_N        (RESET_N),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dip_out        (dip_out10),
        .dip_valid      (dip_valid10),
        .dip_update     (dip_update10),
        .load_err       (load_err10),
        .busy           (busy10)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every dip_update pulse of the 8-byte bank must match the oldest
    // outstanding expected commit.
    always @(negedge clk_sys) begin : monitor
        commit_t e;
        if (dip_update8 === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_update", 80'd1, 80'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("commit_dip_out", {16'h0, dip_out8}, {16'h0, e.out});
                checkOutput("commit_load_err", {79'h0, load_err8}, {79'h0, e.err});
                checkOutput("commit_dip_valid", {79'h0, dip_valid8}, {79'h0, e.valid});
            end
        end
    end

    // Runs one download using the stimAddr/stimData queues. wrAtRise puts the
    // first write in the rise cycle, wrAtFall adds a strobe in the fall cycle,
    // resetAfter >= 0 pulses RESET_N after that many writes.
    task automatic applyStimulus(input logic [7:0] idx, input bit wrAtRise,
                                 input bit wrAtFall, input int resetAfter);
        bit          commitExp;
        bit          busySeen;
        logic [63:0] shadowM;
        logic [63:0] oldLive;
        logic [7:0]  maskM;
        bit          ovfM;
        int          n;
        int          k;
        n         = stimAddr.size();
        commitExp = (idx == 8'd254) && (resetAfter < 0);
        busySeen  = 1'b0;
        oldLive   = mLive;
        shadowM   = mLive;
        maskM     = '0;
        ovfM      = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (stimAddr[j] < 8) begin
                shadowM[stimAddr[j]*8 +: 8] = stimData[j];
                maskM[stimAddr[j]]          = 1'b1;
            end else begin
                ovfM = 1'b1;
            end
        end
        if (commitExp) begin
            mLive  = shadowM;
            mValid = mValid | (&maskM);
            sb.push_back(commit_t'{out: shadowM, err: ~(&maskM) | ovfM, valid: mValid});
        end

        k = 0;
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        if (wrAtRise && n > 0) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(stimAddr[0]);
            ioctl_dout = stimData[0];
            k = 1;
        end
        while (k < n) begin
            @(negedge clk_sys);
            busySeen = busySeen | busy8;
            ioctl_wr = 1'b0;
            if (resetAfter == k) begin
                RESET_N = 1'b0;
                #1;
                checkOutput("rst_mid_dip_out", {16'h0, dip_out8}, {16'h0, DEF8});
                checkOutput("rst_mid_valid", {79'h0, dip_valid8}, 80'd0);
                checkOutput("rst_mid_busy", {79'h0, busy8}, 80'd0);
                mLive  = DEF8;
                mValid = 1'b0;
                @(negedge clk_sys);
                RESET_N = 1'b1;
            end
            @(negedge clk_sys);
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(stimAddr[k]);
            ioctl_dout = stimData[k];
            k++;
        end
        @(negedge clk_sys);
        busySeen = busySeen | busy8;
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        busySeen       = busySeen | busy8;
        ioctl_download = 1'b0;
        if (wrAtFall) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'd0;
            ioctl_dout = 8'hEE;
        end
        @(negedge clk_sys);
        busySeen = busySeen | busy8;
        ioctl_wr = 1'b0;
        checkOutput("upd_low_at_E0", {79'h0, dip_update8}, 80'd0);
        if (commitExp) checkOutput("out_hold_at_E0", {16'h0, dip_out8}, {16'h0, oldLive});
        @(negedge clk_sys);
        checkOutput("upd_at_E1", {79'h0, dip_update8}, {79'h0, commitExp});
        @(negedge clk_sys);
        checkOutput("upd_gone_at_E2", {79'h0, dip_update8}, 80'd0);
        checkOutput("busy_idle_after", {79'h0, busy8}, 80'd0);
        if (idx != 8'd254) checkOutput("busy_never_other_index", {79'h0, busySeen}, 80'd0);
        repeat (2) @(negedge clk_sys);
        stimAddr.delete();
        stimData.delete();
    endtask

    initial begin
        RESET_N        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mLive          = DEF8;
        mValid         = 1'b0;

        repeat (3) @(negedge clk_sys);
        checkOutput("reset_dip_out", {16'h0, dip_out8}, {16'h0, DEF8});
        checkOutput("reset_valid", {79'h0, dip_valid8}, 80'd0);
        checkOutput("reset_busy", {79'h0, busy8}, 80'd0);
        checkOutput("reset_load_err", {79'h0, load_err8}, 80'd0);
        checkOutput("reset_update", {79'h0, dip_update8}, 80'd0);
        RESET_N = 1'b1;
        repeat (3) @(negedge clk_sys);
        $display("[TB] reset released");

        // Full download of all eight bytes.
        for (int j = 0; j < 8; j++) begin
            stimAddr.push_back(j);
            stimData.push_back(8'(17 * (j + 1)));
        end
        applyStimulus(8'd254, 1'b0, 1'b0, -1);
        checkOutput("full_dip_out", {16'h0, dip_out8}, {16'h0, 64'h8877_6655_4433_2211});
        checkOutput("full_load_err", {79'h0, load_err8}, 80'd0);
        checkOutput("full_valid", {79'h0, dip_valid8}, 80'd1);

        // Partial download; the fall-cycle strobe must be ignored too.
        stimAddr.push_back(2);
        stimData.push_back(8'hA5);
        applyStimulus(8'd254, 1'b0, 1'b1, -1);
        checkOutput("partial_dip_out", {16'h0, dip_out8}, {16'h0, 64'h8877_6655_44A5_2211});
        checkOutput("partial_load_err", {79'h0, load_err8}, 80'd1);
        checkOutput("partial_valid", {79'h0, dip_valid8}, 80'd1);

        // Ten bytes: overflow for the 8-byte bank, exact fit for the 10-byte one.
        for (int j = 0; j < 10; j++) begin
            stimAddr.push_back(j);
            stimData.push_back(8'(8'hC0 + j));
        end
        applyStimulus(8'd254, 1'b0, 1'b0, -1);
        checkOutput("ovf_dip_out", {16'h0, dip_out8}, {16'h0, 64'hC7C6_C5C4_C3C2_C1C0});
        checkOutput("ovf_load_err", {79'h0, load_err8}, 80'd1);
        checkOutput("fit10_dip_out", dip_out10, 80'hC9C8_C7C6_C5C4_C3C2_C1C0);
        checkOutput("fit10_load_err", {79'h0, load_err10}, 80'd0);
        checkOutput("fit10_valid", {79'h0, dip_valid10}, 80'd1);

        // Repeated write to one address keeps the last value.
        for (int j = 0; j < 8; j++) begin
            stimAddr.push_back(j);
            stimData.push_back(8'(8'h90 + j));
        end
        stimAddr.push_back(5);
        stimData.push_back(8'h5E);
        applyStimulus(8'd254, 1'b0, 1'b0, -1);
        checkOutput("repeat_dip_out", {16'h0, dip_out8}, {16'h0, 64'h9796_5E94_9392_9190});
        checkOutput("repeat_load_err", {79'h0, load_err8}, 80'd0);

        // ROM download (index 0) must not touch the bank.
        for (int j = 0; j < 8; j++) begin
            stimAddr.push_back(j);
            stimData.push_back(8'(8'hF0 + j));
        end
        applyStimulus(8'd0, 1'b0, 1'b1, -1);
        checkOutput("rom_dip_out", {16'h0, dip_out8}, {16'h0, 64'h9796_5E94_9392_9190});

        // Reset after four writes; rest of that download must be ignored.
        for (int j = 0; j < 8; j++) begin
            stimAddr.push_back(j);
            stimData.push_back(8'(8'h40 + j));
        end
        applyStimulus(8'd254, 1'b0, 1'b0, 4);
        checkOutput("post_rst_dip_out", {16'h0, dip_out8}, {16'h0, DEF8});
        checkOutput("post_rst_valid", {79'h0, dip_valid8}, 80'd0);
        checkOutput("post_rst_load_err", {79'h0, load_err8}, 80'd0);

        // Next download with its first write coincident with the rise.
        for (int j = 0; j < 8; j++) begin
            stimAddr.push_back(j);
            stimData.push_back(8'(8'h60 + j));
        end
        applyStimulus(8'd254, 1'b1, 1'b0, -1);
        checkOutput("rise_wr_dip_out", {16'h0, dip_out8}, {16'h0, 64'h6766_6564_6362_6160});
        checkOutput("rise_wr_load_err", {79'h0, load_err8}, 80'd0);
        checkOutput("rise_wr_valid", {79'h0, dip_valid8}, 80'd1);

        checkOutput("scoreboard_drained", 80'(sb.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
